d_mem_rw: RTL and testbench
===========================

# d_mem_rw

Parametrised read/write data memory: successor to the fixed 256×8 combinational data ROM. It provides one synchronous write port and one registered read port. After every reset it self-initialises to the standard data image (word 0 = 1, word 1 = 2, all others 0). It sits beside the processor datapath as its data store; the datapath gates accesses on `busy`.

## Interface
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 8: address width in bits.
- `DEPTH`, 256: number of words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `busy` out 1: high while the init sequence runs; accesses are ignored.
- `wr_en` in 1: write strobe.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write data.
- `rd_en` in 1: read strobe.
- `rd_addr` in ADDR_W: read address.
- `rd_data` out DATA_W: registered read data; holds its value between reads.
- `rd_valid` out 1: one-cycle pulse marking new `rd_data`.

## Operation
- FSM states are `INIT` and `READY`.
- **Reset:** `rst_n` low forces:
  - the FSM to `INIT`;
  - the init counter to 0;
  - `busy`=1, `rd_valid`=0, `rd_data`=0.
- **INIT:**
  - On each cycle, write the image word to address `cnt`: 1 at address 0, 2 at address 1, 0 elsewhere. Then increment `cnt`.
  - When `cnt` = DEPTH-1 is written, go to `READY` on the next edge.
  - `wr_en` and `rd_en` are ignored; `rd_valid` stays 0.
- **READY:**
  - `wr_en`=1 with `wr_addr` < DEPTH: `mem[wr_addr]` ← `wr_data` at the edge.
  - `rd_en`=1: `rd_data` ← `mem[rd_addr]` and `rd_valid`=1 on the next cycle.
  - `rd_en`=0: `rd_valid`=0 and `rd_data` holds.
- **Out-of-range address (≥ DEPTH):** writes are dropped. Reads return 0 with `rd_valid`=1.
- **Simultaneous read and write, different addresses:** both take effect independently.
- **Simultaneous read and write, same address:** governed by the macro in Configuration.
- **Reset mid-operation:**
  - Any in-flight read is lost and `rd_valid` is forced to 0.
  - Array contents are rewritten by the new `INIT` pass.
  - User writes are never preserved across reset.
- Widths: the counter is `ADDR_W`+1 bits so that DEPTH = 2**ADDR_W terminates without wrap. Data is not truncated or extended.

## Timing
- Read latency is 1 cycle: address and `rd_en` at edge N give `rd_data`/`rd_valid` valid after edge N+1 (valid during cycle N+1).
- Write takes effect at the edge it is sampled. A read issued on the following cycle returns the new value.
- Init duration is exactly DEPTH cycles after `rst_n` deasserts. `busy` falls after the edge that writes address DEPTH-1, so the first accepted access is at cycle DEPTH.
- Back-to-back reads are supported at one per cycle, with no bubbles.

## Configuration
- `D_MEM_BYPASS_EN` defined: write-first. A same-address read and write in the same cycle returns `wr_data` on the next cycle.
- Undefined: read-first. The same case returns the old `mem` content; the write still completes.

## Structure
- Package `d_mem_pkg` holds:
  - the state enum `d_mem_state_t` (`INIT`, `READY`);
  - the init-image constants `D_MEM_INIT0` = 1 and `D_MEM_INIT1` = 2;
  - the function `d_mem_init_word(addr)` returning the image word.
- Sub-module `d_mem_array`: a simple dual-port array (sync write, registered read, optional bypass). It is wrapped by `d_mem_rw`, which owns the FSM, the init counter and address-range checks.

## Test plan
- **Reset, then idle:** `busy`=1 for exactly 256 cycles, then 0. Reads of addresses 0, 1, 2 and 255 return 1, 2, 0, 0 with `rd_valid` one cycle after each request.
- **Write then read:** write 0xA5 to address 0x10, then read 0x10 on the next cycle → `rd_data`=0xA5 and `rd_valid`=1 one cycle later.
- **Same-cycle read and write to address 0x20 (old 0x00, new 0x3C):** with `D_MEM_BYPASS_EN`, read returns 0x3C; without it, read returns 0x00; a follow-up read returns 0x3C in both builds.
- **Accesses during INIT:** `wr_en`/`rd_en` asserted while `busy`=1 → no `rd_valid`; after init, address 0 still reads 1.
- **Reset mid-operation:** write 0xFF to address 1, pulse `rst_n` low mid-burst of reads → `rd_valid` drops immediately and `busy` reasserts; after re-init, address 1 reads 2.
- **DEPTH=100, ADDR_W=8:** write 0x55 to address 150 → dropped; read 150 → 0 with `rd_valid`=1; init takes 100 cycles.

Source files
------------

// File: rtl/d_mem_pkg.sv
// Shared types and init-image helpers for the d_mem_rw data memory.
package d_mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } d_mem_state_t;

  localparam int unsigned D_MEM_INIT0 = 1;
  localparam int unsigned D_MEM_INIT1 = 2;

  // Standard data image: word 0 = 1, word 1 = 2, everything else 0.
  function automatic int unsigned d_mem_init_word(input int unsigned addr);
    if (addr == 0) return D_MEM_INIT0;
    if (addr == 1) return D_MEM_INIT1;
    return 0;
  endfunction

endpackage

// File: rtl/d_mem_array.sv
// Simple dual-port array: synchronous write, registered read.
// D_MEM_BYPASS_EN selects write-first behaviour on a same-address collision.
module d_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rok_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    rd_word = mem_q[raddr_i];
`ifdef D_MEM_BYPASS_EN
    if (we_i && (waddr_i == raddr_i)) rd_word = wdata_i;
`endif
  end

  // Out-of-range reads still update the register, but with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= rok_i ? rd_word : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/d_mem_rw.sv
// Read/write data memory that reloads the standard data image after every reset.
// Build option: D_MEM_BYPASS_EN (write-first on same-address read/write).
module d_mem_rw
  import d_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);

  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  d_mem_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;

  logic              wr_ok, rd_ok;
  logic              arr_we, arr_re;
  logic [IDX_W-1:0]  arr_waddr;
  logic [DATA_W-1:0] arr_wdata;

  assign wr_ok = {1'b0, wr_addr_i} < DEPTH_C;
  assign rd_ok = {1'b0, rd_addr_i} < DEPTH_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_C) state_d = READY;
    end
  end

  // INIT owns the write port to lay down the image; user strobes are dropped.
  always_comb begin
    busy_o     = 1'b0;
    arr_we     = 1'b0;
    arr_waddr  = wr_addr_i[IDX_W-1:0];
    arr_wdata  = wr_data_i;
    arr_re     = 1'b0;
    rd_valid_d = 1'b0;
    case (state_q)
      INIT: begin
        busy_o    = 1'b1;
        arr_we    = 1'b1;
        arr_waddr = cnt_q[IDX_W-1:0];
        arr_wdata = DATA_W'(d_mem_init_word(32'(cnt_q)));
      end
      READY: begin
        arr_we     = wr_en_i && wr_ok;
        arr_re     = rd_en_i;
        rd_valid_d = rd_en_i;
      end
      default: ;
    endcase
  end

  d_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .rok_i   (rd_ok),
    .raddr_i (rd_addr_i[IDX_W-1:0]),
    .rdata_o (rd_data_o)
  );

  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_d_mem_rw.sv
// Directed bench for d_mem_rw: full-depth instance plus a DEPTH=100 instance.
module tb_d_mem_rw;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic       wr_en, rd_en;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       rd_valid;

  logic       rst_n_s;
  logic       busy_s;
  logic       wr_en_s, rd_en_s;
  logic [7:0] wr_addr_s, wr_data_s, rd_addr_s, rd_data_s;
  logic       rd_valid_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  d_mem_rw #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy_o     (busy),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid)
  );

  d_mem_rw #(.DATA_W(8), .ADDR_W(8), .DEPTH(100)) u_dut_s (
    .clk        (clk),
    .rst_n      (rst_n_s),
    .busy_o     (busy_s),
    .wr_en_i    (wr_en_s),
    .wr_addr_i  (wr_addr_s),
    .wr_data_i  (wr_data_s),
    .rd_en_i    (rd_en_s),
    .rd_addr_i  (rd_addr_s),
    .rd_data_o  (rd_data_s),
    .rd_valid_o (rd_valid_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops; also notes any rd_valid seen meanwhile.
  task automatic wait_init(output int n, output int vld_seen);
    n = 0;
    vld_seen = 0;
    while (busy && n < 400) begin
      tick();
      n++;
      if (rd_valid) vld_seen++;
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check_eq({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
    check_eq(tag, {24'b0, rd_data}, {24'b0, exp});
  endtask

  initial begin
    int n, vs;
    logic [7:0] exp_col;

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    rst_n_s = 1'b0; wr_en_s = 1'b0; rd_en_s = 1'b0;
    wr_addr_s = '0; wr_data_s = '0; rd_addr_s = '0;
    repeat (3) tick();
    check_eq("rst_busy", {31'b0, busy}, 32'd1);
    check_eq("rst_vld", {31'b0, rd_valid}, 32'd0);
    check_eq("rst_data", {24'b0, rd_data}, 32'd0);

    // Hammer the access strobes throughout init; they must all be ignored.
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 8'h00; wr_data = 8'h77;
    rd_en = 1'b1; rd_addr = 8'h00;
    wait_init(n, vs);
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("init_len", n, 32'd256);
    check_eq("init_no_vld", vs, 32'd0);

    do_read("rd_a0", 8'd0, 8'd1);
    do_read("rd_a1", 8'd1, 8'd2);
    do_read("rd_a2", 8'd2, 8'd0);
    do_read("rd_a255", 8'd255, 8'd0);

    // Idle cycle: valid drops, data holds last value.
    tick();
    check_eq("idle_vld", {31'b0, rd_valid}, 32'd0);
    check_eq("idle_hold", {24'b0, rd_data}, 32'd0);

    do_write(8'h10, 8'hA5);
    do_read("wr_rd_10", 8'h10, 8'hA5);

    // Back-to-back reads, no bubble.
    rd_en = 1'b1; rd_addr = 8'd1;
    tick();
    check_eq("b2b_v0", {31'b0, rd_valid}, 32'd1);
    check_eq("b2b_d0", {24'b0, rd_data}, 32'd2);
    rd_addr = 8'h10;
    tick();
    rd_en = 1'b0;
    check_eq("b2b_v1", {31'b0, rd_valid}, 32'd1);
    check_eq("b2b_d1", {24'b0, rd_data}, 32'hA5);

    // Same-address collision at 0x20.
`ifdef D_MEM_BYPASS_EN
    exp_col = 8'h3C;
`else
    exp_col = 8'h00;
`endif
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'h3C;
    rd_en = 1'b1; rd_addr = 8'h20;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("col_vld", {31'b0, rd_valid}, 32'd1);
    check_eq("col_data", {24'b0, rd_data}, {24'b0, exp_col});
    do_read("col_follow", 8'h20, 8'h3C);

    // Different-address read and write in the same cycle.
    wr_en = 1'b1; wr_addr = 8'h30; wr_data = 8'h11;
    rd_en = 1'b1; rd_addr = 8'h10;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("diff_rd", {24'b0, rd_data}, 32'hA5);
    do_read("diff_wr", 8'h30, 8'h11);

    // Reset in the middle of a read burst.
    do_write(8'd1, 8'hFF);
    do_read("pre_rst", 8'd1, 8'hFF);
    rd_en = 1'b1; rd_addr = 8'd1;
    tick();
    tick();
    check_eq("burst_vld", {31'b0, rd_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", {31'b0, rd_valid}, 32'd0);
    check_eq("mid_rst_busy", {31'b0, busy}, 32'd1);
    rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_init(n, vs);
    check_eq("reinit_len", n, 32'd256);
    do_read("reinit_a1", 8'd1, 8'd2);
    do_read("reinit_a10", 8'h10, 8'h00);

    // DEPTH=100 instance: range checks at and beyond the top word.
    rst_n_s = 1'b1;
    n = 0;
    while (busy_s && n < 400) begin
      tick();
      n++;
    end
    check_eq("s_init_len", n, 32'd100);
    wr_en_s = 1'b1; wr_addr_s = 8'd150; wr_data_s = 8'h55;
    tick();
    wr_addr_s = 8'd99; wr_data_s = 8'h66;
    tick();
    wr_en_s = 1'b0;
    rd_en_s = 1'b1; rd_addr_s = 8'd150;
    tick();
    check_eq("s_oor_vld", {31'b0, rd_valid_s}, 32'd1);
    check_eq("s_oor_data", {24'b0, rd_data_s}, 32'd0);
    rd_addr_s = 8'd22;
    tick();
    check_eq("s_alias22", {24'b0, rd_data_s}, 32'd0);
    rd_addr_s = 8'd99;
    tick();
    check_eq("s_top_vld", {31'b0, rd_valid_s}, 32'd1);
    check_eq("s_top_data", {24'b0, rd_data_s}, 32'h66);
    rd_addr_s = 8'd0;
    tick();
    rd_en_s = 1'b0;
    check_eq("s_a0", {24'b0, rd_data_s}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
